// File: rtl/xorcollapse.sv
// xorcollapse: rebuilds an n-bit seed r from its stream of pairwise XORs
// p[k] = r[i]^r[j] (i<j, ascending k) together with a known r[0] (anchor).
// The first n-1 pair bits (0,j) determine r; every later pair bit is
// cross-checked against the reconstruction, and the first inconsistent
// index is reported alongside the result.

module xorcollapse #(
    parameter int RNDSIZE = 8,
    localparam int NPAIR = RNDSIZE * (RNDSIZE - 1) / 2,
    localparam int KW = $clog2(NPAIR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               anchor,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RNDSIZE-1:0] out_r,
    output logic               out_err,
    output logic [KW-1:0]      out_badidx
);

    localparam int IW = $clog2(RNDSIZE);
    localparam logic [IW-1:0] JLAST = IW'(RNDSIZE - 1);
    localparam logic [KW-1:0] KLAST = KW'(NPAIR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [RNDSIZE-1:0]  r;
    logic [IW-1:0]       i;
    logic [IW-1:0]       j;
    logic [KW-1:0]       k;
    logic                err;
    logic [KW-1:0]       badidx;
    logic                xfer;
    logic                mismatch;

    assign xfer     = in_valid && in_ready;
    assign mismatch = in_bit != (r[i] ^ r[j]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  if (xfer && j == JLAST) state_next = CHECK;
            CHECK: if (xfer && k == KLAST) state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            LOAD, CHECK: in_ready  = 1'b1;
            DONE:        out_valid = 1'b1;
            default: ;
        endcase
    end

    // Reconstruction, pair indexing and first-error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r      <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            err    <= 1'b0;
            badidx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        r[0]   <= anchor;
                        i      <= '0;
                        j      <= IW'(1);
                        k      <= '0;
                        err    <= 1'b0;
                        badidx <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        // r[0] holds the anchor sampled at start
                        r[j] <= r[0] ^ in_bit;
                        if (j == JLAST) begin
                            i <= IW'(1);
                            j <= IW'(2);
                        end else begin
                            j <= j + IW'(1);
                        end
                        k <= k + KW'(1);
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (mismatch && !err) begin
                            err    <= 1'b1;
                            badidx <= k;
                        end
                        // j restarts just above the incremented i
                        if (j == JLAST) begin
                            i <= i + IW'(1);
                            j <= i + IW'(2);
                        end else begin
                            j <= j + IW'(1);
                        end
                        k <= k + KW'(1);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign out_r      = r;
    assign out_err    = err;
    assign out_badidx = badidx;

endmodule

// File: tb/tb_xorcollapse.sv
// Testbench for xorcollapse (n = 4): directed table, hand-written
// corner sequences and randomized frames against a pair-rule model.

module tb_xorcollapse;

    localparam int N  = 4;
    localparam int NP = N * (N - 1) / 2;
    localparam int KW = $clog2(NP);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          anchor = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_r;
    logic          out_err;
    logic [KW-1:0] out_badidx;

    int vectors = 0;
    int miscompares = 0;

    xorcollapse #(.RNDSIZE(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .anchor(anchor),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_err(out_err), .out_badidx(out_badidx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          a;
        logic [NP-1:0] s;      // s[k] is pair bit k
        logic [N-1:0]  r;
        logic          e;
        logic [KW-1:0] b;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: r[0]=anchor, r[j]=anchor^p(0,j); every pair (i,j), i>=1,
    // must equal r[i]^r[j]; report the lowest failing k.
    function automatic void model(input logic a, input logic [NP-1:0] s,
                                  output logic [N-1:0] r, output logic e,
                                  output logic [KW-1:0] b);
        int unsigned k;
        r = '0;
        e = 1'b0;
        b = '0;
        r[0] = a;
        for (int jj = 1; jj < N; jj++) r[jj] = a ^ s[jj-1];
        for (int ii = 1; ii < N - 1; ii++) begin
            for (int jj = ii + 1; jj < N; jj++) begin
                k = ii * N - ii * (ii + 1) / 2 + jj - ii - 1;
                if (!e && s[k] != (r[ii] ^ r[jj])) begin
                    e = 1'b1;
                    b = KW'(k);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame and checks result, hold stability and return to IDLE.
    task automatic run_frame(input logic a, input logic [NP-1:0] s,
                             input logic [N-1:0] er, input logic ee,
                             input logic [KW-1:0] eb, input int maxgap,
                             input int hold, input bit start_in_done);
        start = 1'b1;
        anchor = a;
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        start = 1'b0;
        anchor = ~a;   // anchor must have been sampled with start
        for (int kk = 0; kk < NP; kk++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int q = 0; q < g; q++) begin
                in_valid = 1'b0;
                in_bit = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_bit = s[kk];
            check("beat_in_ready", {31'd0, in_ready}, 32'd1);
            check("beat_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("out_r", {28'd0, out_r}, {28'd0, er});
        check("out_err", {31'd0, out_err}, {31'd0, ee});
        check("out_badidx", {29'd0, out_badidx}, {29'd0, eb});
        for (int h = 0; h < hold; h++) begin
            start = start_in_done;
            in_valid = 1'b1;
            in_bit = 1'($urandom);
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_r", {28'd0, out_r}, {28'd0, er});
            check("hold_err", {31'd0, out_err}, {31'd0, ee});
            check("hold_badidx", {29'd0, out_badidx}, {29'd0, eb});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = start_in_done;   // simultaneous start is dropped
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("no_restart", {31'd0, in_ready}, 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        logic [N-1:0]  mr;
        logic          me;
        logic [KW-1:0] mb;

        tbl[0] = '{a: 1'b1, s: 6'b101010, r: 4'b1011, e: 1'b0, b: 3'd0};
        tbl[1] = '{a: 1'b0, s: 6'b101010, r: 4'b0100, e: 1'b0, b: 3'd0};
        tbl[2] = '{a: 1'b1, s: 6'b111010, r: 4'b1011, e: 1'b1, b: 3'd4};
        tbl[3] = '{a: 1'b1, s: 6'b000010, r: 4'b1011, e: 1'b1, b: 3'd3};
        tbl[4] = '{a: 1'b1, s: 6'b101011, r: 4'b1001, e: 1'b1, b: 3'd3};
        tbl[5] = '{a: 1'b1, s: 6'b001010, r: 4'b1011, e: 1'b1, b: 3'd5};

        // Reset state
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_r", {28'd0, out_r}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_badidx", {29'd0, out_badidx}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed table
        foreach (tbl[t]) begin
            run_frame(tbl[t].a, tbl[t].s, tbl[t].r, tbl[t].e, tbl[t].b, 0, 1, 1'b0);
        end

        // Stalls of 3 cycles between beats, 5-cycle hold with start pulsed
        start = 1'b1;
        anchor = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < NP; kk++) begin
            logic [NP-1:0] nom;
            nom = 6'b101010;
            if (kk > 0) begin
                in_valid = 1'b0;
                in_bit = ~nom[kk];
                tick(); tick(); tick();
                check("stall_in_ready", {31'd0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_bit = nom[kk];
            tick();
        end
        in_valid = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_r", {28'd0, out_r}, 32'hB);
        for (int h = 0; h < 5; h++) begin
            start = (h == 2);
            tick();
            check("stall_hold_r", {28'd0, out_r}, 32'hB);
            check("stall_hold_err", {31'd0, out_err}, 32'd0);
            check("stall_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_idle", {31'd0, out_valid | in_ready}, 32'd0);

        // Reset mid-frame after 3 accepted beats
        start = 1'b1;
        anchor = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_r", {28'd0, out_r}, 32'd0);
        check("mrst_out_err", {31'd0, out_err}, 32'd0);
        check("mrst_badidx", {29'd0, out_badidx}, 32'd0);
        tick();
        check("mrst_hold_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, in_ready}, 32'd0);
        run_frame(1'b1, 6'b101010, 4'b1011, 1'b0, 3'd0, 0, 1, 1'b0);

        // Randomized frames against the model
        for (int f = 0; f < 60; f++) begin
            logic [N-1:0]  seed;
            logic [NP-1:0] s;
            int unsigned   kk;
            seed = N'($urandom);
            kk = 0;
            for (int ii = 0; ii < N - 1; ii++)
                for (int jj = ii + 1; jj < N; jj++) begin
                    s[kk] = seed[ii] ^ seed[jj];
                    kk++;
                end
            if ($urandom_range(0, 2) != 0) s[$urandom_range(0, NP - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) s[$urandom_range(0, NP - 1)] ^= 1'b1;
            model(seed[0], s, mr, me, mb);
            run_frame(seed[0], s, mr, me, mb, 2, int'($urandom_range(0, 3)),
                      1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
